// File: rtl/ant_launch_scheduler.sv
// Forward-ant launch scheduler sharing the router local injection port.
// Macro ANT_LAUNCH_DROP_STATS_EN enables the lost-launch counter.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   i_en                    launch timer enable
//   i_local_data/val        normal packet from the processing element
//   o_local_rdy             normal packet accepted when high with i_local_val
//   o_data/o_data_val       one-entry registered output buffer
//   i_data_rdy              router accepts o_data
//   o_ant_count             forward ants launched (wraps)
//   o_ant_drop_count        timer expiries lost while an ant was pending

package ant_launch_scheduler_pkg;
  typedef struct packed {
    logic        ant;
    logic        forward;
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [3:0]  x_source;
    logic [3:0]  y_source;
    logic [15:0] payload;
  } packet_t;
endpackage

module ant_launch_scheduler
  import ant_launch_scheduler_pkg::*;
#(
  parameter int X_LOC         = 0,
  parameter int Y_LOC         = 0,
  parameter int X_NODES       = 4,
  parameter int Y_NODES       = 4,
  parameter int LAUNCH_PERIOD = 256,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  input  packet_t     i_local_data,
  input  logic        i_local_val,
  output logic        o_local_rdy,
  output packet_t     o_data,
  output logic        o_data_val,
  input  logic        i_data_rdy,
  output logic [15:0] o_ant_count,
  output logic [15:0] o_ant_drop_count
);

  localparam int XW = (X_NODES > 1) ? $clog2(X_NODES) : 1;
  localparam int YW = (Y_NODES > 1) ? $clog2(Y_NODES) : 1;
  localparam int TW = $clog2(LAUNCH_PERIOD);
  localparam int SW = (STARVE_LIMIT > 0) ?
                      $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [XW-1:0] LX   = XW'(X_LOC);
  localparam logic [YW-1:0] LY   = YW'(Y_LOC);
  localparam logic [XW-1:0] XMAX = XW'(X_NODES - 1);
  localparam logic [YW-1:0] YMAX = YW'(Y_NODES - 1);
  localparam logic [TW-1:0] TMAX = TW'(LAUNCH_PERIOD - 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

  // First raster node that is not this router.
  localparam bit AT_ORIGIN = (X_LOC == 0) && (Y_LOC == 0);
  localparam logic [XW-1:0] FX =
    (AT_ORIGIN && X_NODES > 1) ? XW'(1) : '0;
  localparam logic [YW-1:0] FY =
    (AT_ORIGIN && X_NODES == 1) ? YW'(1) : '0;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_NORM,
    S_ANT
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            ant_pending;
  logic [SW-1:0]   starve;
  logic [XW-1:0]   dx;
  logic [YW-1:0]   dy;
  logic [XW-1:0]   nxt_x;
  logic [YW-1:0]   nxt_y;
  logic [XW-1:0]   s1_x;
  logic [YW-1:0]   s1_y;
  packet_t         ant_pkt;

  logic slot_free;
  logic expire;
  logic ant_sel;
  logic ant_gnt;
  logic norm_gnt;

  function automatic logic [XW+YW-1:0] step(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    nx = x + 1'b1;
    ny = y;
    if (x == XMAX) begin
      nx = '0;
      ny = (y == YMAX) ? '0 : y + 1'b1;
    end
    return {ny, nx};
  endfunction

  assign slot_free   = ~o_data_val | i_data_rdy;
  assign expire      = i_en & (timer == TMAX);
  assign ant_sel     = ant_pending &
                       (~i_local_val | (starve >= SMAX));
  assign ant_gnt     = slot_free & ant_sel;
  assign norm_gnt    = slot_free & i_local_val & ~ant_sel;
  assign o_local_rdy = slot_free & ~ant_sel;
  assign o_data_val  = (state != S_EMPTY);

  // Next destination, stepping twice to skip this router.
  always_comb begin
    {s1_y, s1_x} = step(dx, dy);
    nxt_x = s1_x;
    nxt_y = s1_y;
    if (s1_x == LX && s1_y == LY) begin
      {nxt_y, nxt_x} = step(s1_x, s1_y);
    end
  end

  always_comb begin
    ant_pkt          = '0;
    ant_pkt.ant      = 1'b1;
    ant_pkt.forward  = 1'b1;
    ant_pkt.x_dest   = 4'(dx);
    ant_pkt.y_dest   = 4'(dy);
    ant_pkt.x_source = 4'(X_LOC);
    ant_pkt.y_source = 4'(Y_LOC);
  end

  // An expiry on the grant edge re-arms the pending flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer       <= '0;
      ant_pending <= 1'b0;
    end else begin
      if (i_en) begin
        timer <= expire ? '0 : timer + 1'b1;
      end
      if (expire) begin
        ant_pending <= 1'b1;
      end else if (ant_gnt) begin
        ant_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve <= '0;
    end else if (ant_gnt) begin
      starve <= '0;
    end else if (norm_gnt) begin
      if (!ant_pending) begin
        starve <= '0;
      end else if (starve != SMAX) begin
        starve <= starve + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dx          <= FX;
      dy          <= FY;
      o_ant_count <= '0;
    end else if (ant_gnt) begin
      dx          <= nxt_x;
      dy          <= nxt_y;
      o_ant_count <= o_ant_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_EMPTY;
      o_data <= '0;
    end else if (slot_free) begin
      unique case (1'b1)
        ant_gnt: begin
          state  <= S_ANT;
          o_data <= ant_pkt;
        end
        norm_gnt: begin
          state  <= S_NORM;
          o_data <= i_local_data;
        end
        default: begin
          state <= S_EMPTY;
        end
      endcase
    end
  end

`ifdef ANT_LAUNCH_DROP_STATS_EN
  logic drop_inc;

  assign drop_inc = expire & ant_pending & ~ant_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_ant_drop_count <= '0;
    end else if (drop_inc) begin
      o_ant_drop_count <= o_ant_drop_count + 16'd1;
    end
  end
`else
  assign o_ant_drop_count = '0;
`endif

endmodule

// File: tb/tb_ant_launch_scheduler.sv
// Directed bench for ant_launch_scheduler.
// Two instances: router (0,0) and router (3,3), LAUNCH_PERIOD=8.

module tb_ant_launch_scheduler;
  import ant_launch_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  packet_t     l_data;
  logic        l_val;
  logic        l_rdy;
  packet_t     d_data;
  logic        d_val;
  logic        d_rdy;
  logic [15:0] a_cnt;
  logic [15:0] a_drop;

  logic        rst1_n;
  packet_t     d1_data;
  logic        d1_val;
  logic        l1_rdy;
  logic [15:0] a1_cnt;
  logic [15:0] a1_drop;
  packet_t     zero_pkt;

  int checks = 0;
  int errors = 0;
  logic [7:0] dq[$];

  always #5 clk = ~clk;

  ant_launch_scheduler #(
    .X_LOC(0), .Y_LOC(0), .X_NODES(4), .Y_NODES(4),
    .LAUNCH_PERIOD(8), .STARVE_LIMIT(4)
  ) dut0 (
    .clk(clk), .reset_n(rst_n), .i_en(en),
    .i_local_data(l_data), .i_local_val(l_val),
    .o_local_rdy(l_rdy), .o_data(d_data),
    .o_data_val(d_val), .i_data_rdy(d_rdy),
    .o_ant_count(a_cnt), .o_ant_drop_count(a_drop)
  );

  ant_launch_scheduler #(
    .X_LOC(3), .Y_LOC(3), .X_NODES(4), .Y_NODES(4),
    .LAUNCH_PERIOD(8), .STARVE_LIMIT(4)
  ) dut1 (
    .clk(clk), .reset_n(rst1_n), .i_en(1'b1),
    .i_local_data(zero_pkt), .i_local_val(1'b0),
    .o_local_rdy(l1_rdy), .o_data(d1_data),
    .o_data_val(d1_val), .i_data_rdy(1'b1),
    .o_ant_count(a1_cnt), .o_ant_drop_count(a1_drop)
  );

  always @(negedge clk) begin
    if (rst1_n && d1_val) begin
      dq.push_back({d1_data.x_dest, d1_data.y_dest});
    end
  end

  typedef struct {
    logic        lval;
    logic        drdy;
    logic        exp_lrdy;
    logic        exp_ant;
    logic [15:0] exp_pay;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(logic lv, logic dr, logic lr,
                              logic an, logic [15:0] p);
    vec_t v;
    v.lval = lv; v.drdy = dr; v.exp_lrdy = lr;
    v.exp_ant = an; v.exp_pay = p;
    return v;
  endfunction

  initial begin
    // Starvation table: edge n grants payload n, edge 13 is the ant.
    vt[0]  = mk(1, 1, 1, 0, 16'd1);
    vt[1]  = mk(1, 1, 1, 0, 16'd2);
    vt[2]  = mk(1, 1, 1, 0, 16'd3);
    vt[3]  = mk(1, 1, 1, 0, 16'd4);
    vt[4]  = mk(1, 1, 1, 0, 16'd5);
    vt[5]  = mk(1, 1, 1, 0, 16'd6);
    vt[6]  = mk(1, 1, 1, 0, 16'd7);
    vt[7]  = mk(1, 1, 1, 0, 16'd8);
    vt[8]  = mk(1, 1, 1, 0, 16'd9);
    vt[9]  = mk(1, 1, 1, 0, 16'd10);
    vt[10] = mk(1, 1, 1, 0, 16'd11);
    vt[11] = mk(1, 1, 1, 0, 16'd12);
    vt[12] = mk(1, 1, 0, 1, 16'd0);
    vt[13] = mk(1, 1, 1, 0, 16'd14);

    zero_pkt = '0;
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    en     = 1'b1;
    l_val  = 1'b0;
    l_data = '0;
    d_rdy  = 1'b1;
    #3;
    chk("rst_val", 32'(d_val), 0);
    chk("rst_data_zero", 32'(d_data != '0), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_drop", 32'(a_drop), 0);
    chk("rst_lrdy", 32'(l_rdy), 1);

    // Periodic launches from (0,0).
    do_reset();
    for (int n = 1; n <= 33; n++) begin
      tick();
      chk("launch_val", 32'(d_val),
          32'((n >= 9) && (n % 8 == 1)));
      if ((n >= 9) && (n % 8 == 1)) begin
        int k;
        k = (n - 9) / 8;
        chk("launch_ant", 32'(d_data.ant), 1);
        chk("launch_fwd", 32'(d_data.forward), 1);
        chk("launch_xd", 32'(d_data.x_dest),
            (k == 3) ? 0 : 32'(k + 1));
        chk("launch_yd", 32'(d_data.y_dest),
            (k == 3) ? 1 : 0);
      end
    end
    chk("launch_cnt", 32'(a_cnt), 4);

    // Starvation limit with continuous local traffic.
    l_val = 1'b1;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      l_val = vt[i].lval;
      d_rdy = vt[i].drdy;
      l_data = '0;
      l_data.payload = 16'(i + 1);
      #1;
      chk("starve_lrdy", 32'(l_rdy), 32'(vt[i].exp_lrdy));
      tick();
      chk("starve_val", 32'(d_val), 1);
      chk("starve_ant", 32'(d_data.ant), 32'(vt[i].exp_ant));
      chk("starve_pay", 32'(d_data.payload),
          32'(vt[i].exp_pay));
    end
    chk("starve_cnt", 32'(a_cnt), 1);

    // Backpressure hold with a normal packet buffered.
    d_rdy = 1'b0;
    l_data = '0;
    l_data.payload = 16'd100;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_lrdy", 32'(l_rdy), 0);
      tick();
      chk("hold_val", 32'(d_val), 1);
      chk("hold_pay", 32'(d_data.payload), 14);
      chk("hold_cnt", 32'(a_cnt), 1);
    end
    d_rdy = 1'b1;
    #1;
    chk("release_lrdy", 32'(l_rdy), 1);
    tick();
    chk("release_pay", 32'(d_data.payload), 100);
    l_data.payload = 16'd101;
    tick();
    chk("release_next", 32'(d_data.payload), 101);

    // Asynchronous reset with an ant held.
    l_val = 1'b0;
    d_rdy = 1'b1;
    do_reset();
    repeat (9) tick();
    chk("mid_ant", 32'(d_data.ant), 1);
    d_rdy = 1'b0;
    repeat (2) tick();
    chk("mid_held", 32'(d_val), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_val", 32'(d_val), 0);
    chk("async_cnt", 32'(a_cnt), 0);
    chk("async_data", 32'(d_data != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    d_rdy = 1'b1;
    repeat (8) tick();
    chk("after_rst_idle", 32'(d_val), 0);
    tick();
    chk("after_rst_val", 32'(d_val), 1);
    chk("after_rst_xd", 32'(d_data.x_dest), 1);
    chk("after_rst_yd", 32'(d_data.y_dest), 0);

    // Lost expiries under sustained backpressure.
    d_rdy = 1'b0;
    do_reset();
    repeat (44) tick();
    chk("drop_cnt", 32'(a_cnt), 1);
    chk("drop_val", 32'(d_val), 1);
`ifdef ANT_LAUNCH_DROP_STATS_EN
    chk("drop_drops", 32'(a_drop), 3);
`else
    chk("drop_drops", 32'(a_drop), 0);
`endif

    // Raster order from (3,3).
    d_rdy = 1'b1;
    @(negedge clk);
    rst1_n = 1'b1;
    repeat (129) tick();
    @(negedge clk);
    #1;
    chk("raster_n", 32'(dq.size()), 16);
    begin
      int idx;
      idx = 0;
      for (int y = 0; y < 4; y++) begin
        for (int x = 0; x < 4; x++) begin
          if (!(x == 3 && y == 3) && idx < dq.size()) begin
            chk("raster_dst", 32'(dq[idx]),
                32'(x * 16 + y));
            idx++;
          end
        end
      end
      if (dq.size() > 15) begin
        chk("raster_wrap", 32'(dq[15]), 0);
      end
    end
    chk("raster_cnt", 32'(a1_cnt), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ant_launch_scheduler.md
Name: ant_launch_scheduler

Overview:
- Per-router scheduler that periodically launches forward ant packets towards every other node in the mesh, one destination per launch, in raster order.
- Shares the router's local injection port between the node's normal traffic and these generated ants.
- Holds a one-entry registered output buffer with a valid/ready handshake.
- Sits between the processing element and the router's local input, alongside the ant agent and routing table of the same router.

Parameters:
- X_LOC, 0, this router's X coordinate
- Y_LOC, 0, this router's Y coordinate
- X_NODES, 4, mesh width
- Y_NODES, 4, mesh height
- LAUNCH_PERIOD, 256, cycles between ant launch requests; must be ≥2
- STARVE_LIMIT, 4, maximum consecutive normal grants while an ant is pending

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- i_en  input  1  launch timer enable
- i_local_data  input  packet_t  normal packet from the processing element
- i_local_val  input  1  i_local_data valid
- o_local_rdy  output  1  normal packet accepted this cycle when high together with i_local_val
- o_data  output  packet_t  packet to the router local input
- o_data_val  output  1  o_data valid
- i_data_rdy  input  1  router accepts o_data
- o_ant_count  output  16  forward ants launched; wraps at 2^16
- o_ant_drop_count  output  16  see Optional Feature

Behaviour:
- Reset, asynchronous and active-low, effective immediately, also mid-transfer:
  - o_data_val=0, o_data=0, o_ant_count=0, o_ant_drop_count=0
  - timer=0, ant_pending=0, starve=0
  - destination counter (dx,dy) = first node ≠ (X_LOC,Y_LOC) in raster order (x fastest)
- Timer:
  - Increments each cycle while i_en=1; holds while i_en=0.
  - At LAUNCH_PERIOD-1 it wraps to 0 and sets ant_pending.
  - An expiry while ant_pending is already 1 is lost; it is counted only under the Optional Feature.
  - A pending ant is still issued after i_en drops.
- Buffer slot is free when o_data_val=0 or (o_data_val & i_data_rdy).
- Selection, evaluated when the slot is free:
  - ant_sel = ant_pending & (~i_local_val | starve ≥ STARVE_LIMIT)
  - o_local_rdy = slot_free & ~ant_sel (combinational)
- Grant of a normal packet (slot_free & i_local_val & ~ant_sel):
  - o_data ← i_local_data and o_data_val ← 1 on the next edge.
  - starve increments (saturating) if ant_pending=1; otherwise starve stays 0.
- Grant of an ant (slot_free & ant_sel):
  - o_data ← packet with ant=1, forward=1, x_dest=dx, y_dest=dy, x_source=X_LOC, y_source=Y_LOC, all other fields 0; o_data_val ← 1.
  - ant_pending ← 0 unless a timer expiry occurs on the same edge; the expiry wins and ant_pending stays 1.
  - starve ← 0; o_ant_count increments.
  - (dx,dy) advances raster-order, skipping (X_LOC,Y_LOC) and wrapping from (X_NODES-1, Y_NODES-1) to the first valid node.
- Slot free with nothing selected: o_data_val ← 0.
- While o_data_val=1 and i_data_rdy=0: o_data is held stable and o_local_rdy=0.
- Throughput and latency:
  - One packet per cycle under continuous i_data_rdy.
  - Latency from acceptance to o_data_val is 1 cycle.
- State machine:
  - EMPTY: o_data_val=0.
  - NORM: holding a normal packet.
  - ANT: holding an ant.
  - Transitions occur only on slot-free edges: to NORM or ANT per the selection above, otherwise to EMPTY.
- Arithmetic: destination counters are $clog2 wide per axis; counters wrap rather than saturate, except starve, which saturates.

Optional Feature:
- Macro: ANT_LAUNCH_DROP_STATS_EN.
- Defined: o_ant_drop_count increments (wrapping at 2^16) on every timer expiry that occurs while ant_pending=1 and no ant grant happens on that same edge.
- Undefined: o_ant_drop_count is tied to 0 and the logic is not built.

Test Plan:
- Reset with X_LOC=0, Y_LOC=0, LAUNCH_PERIOD=8, i_en=1, no local traffic, i_data_rdy=1 → first ant on o_data_val in cycle 9 with dest (1,0); next ants (2,0),(3,0),(0,1) at 8-cycle spacing; o_ant_count=4.
- With X_LOC=3, Y_LOC=3, cycle 15 ants → destinations (0,0)…(2,3) in order, (3,3) skipped, then wrap to (0,0).
- Continuous i_local_val=1, STARVE_LIMIT=4, ant pending → exactly 4 normal grants, then 1 ant grant with o_local_rdy=0 that cycle, then normal traffic resumes.
- Hold i_data_rdy=0 for 5 cycles with a packet in the buffer → o_data stable, o_local_rdy=0, no counter changes; on release the held packet transfers and the next packet appears 1 cycle later.
- Assert reset_n=0 mid-hold with an ant buffered → o_data_val=0 immediately (asynchronously); after release the first ant goes again to the first destination.
- Macro defined, i_data_rdy=0 for 3×LAUNCH_PERIOD with an ant pending → o_ant_drop_count=3; macro undefined → o_ant_drop_count stays 0.
